data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_timer.sv | 43 ++++
 rtl/data_mem_responder.sv | 86 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data memory responder: timer register map,
// STATUS match bit position and CMP reset value.
package dmem_pkg;

   localparam logic [31:0] TMR_COUNT_OFS  = 32'h0000_0000;
   localparam logic [31:0] TMR_CMP_OFS    = 32'h0000_0004;
   localparam logic [31:0] TMR_STATUS_OFS = 32'h0000_0008;
   localparam int unsigned TMR_MATCH_BIT  = 0;
   localparam logic [31:0] TMR_CMP_RST    = 32'hFFFF_FFFF;

   typedef struct packed {
      logic count;
      logic cmp;
      logic status;
   } tmr_sel_t;

endpackage

// File: rtl/dmem_timer.sv
// Free-running COUNT with CMP match flag; STATUS write-1-to-clear, where a
// match in the same cycle takes priority over the clear.
module dmem_timer
   import dmem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  tmr_sel_t    wr_sel,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] cmp,
   output logic        match
);

   logic [31:0] count_q, count_d;
   logic [31:0] cmp_q, cmp_d;
   logic        match_q, match_d;

   always_comb begin
      count_d = wr_sel.count ? wdata : count_q + 32'd1;
      cmp_d   = wr_sel.cmp ? wdata : cmp_q;
      match_d = match_q;
      if (wr_sel.status && wdata[TMR_MATCH_BIT]) match_d = 1'b0;
      if (count_q == cmp_q) match_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         cmp_q   <= TMR_CMP_RST;
         match_q <= 1'b0;
      end else begin
         count_q <= count_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
      end
   end

   assign count = count_q;
   assign cmp   = cmp_q;
   assign match = match_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-cycle data memory: RAM with combinational read plus an optional
// timer block, compiled in only when DMEM_TIMER_EN is defined.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH      = 64,
   parameter logic [31:0] TIMER_BASE = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MisalignErr,
   output logic        TimerIrq
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic          aligned;
   logic          ram_hit;
   logic [AW-1:0] widx;
   logic          misalign_q, misalign_d;

   assign aligned = (Addr[1:0] == 2'b00);
   assign ram_hit = (Addr[31:AW+2] == '0);
   assign widx    = Addr[AW+1:2];

   // RAM is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && MemWrite && aligned && ram_hit) mem_q[widx] <= WriteData;
   end

   always_comb misalign_d = misalign_q | (MemWrite & ~aligned);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end

   assign MisalignErr = misalign_q;

`ifdef DMEM_TIMER_EN
   tmr_sel_t    tmr_wr;
   logic [31:0] tmr_count;
   logic [31:0] tmr_cmp;
   logic        tmr_match;

   always_comb begin
      tmr_wr        = '0;
      tmr_wr.count  = MemWrite && aligned && !ram_hit && (Addr == TIMER_BASE + TMR_COUNT_OFS);
      tmr_wr.cmp    = MemWrite && aligned && !ram_hit && (Addr == TIMER_BASE + TMR_CMP_OFS);
      tmr_wr.status = MemWrite && aligned && !ram_hit && (Addr == TIMER_BASE + TMR_STATUS_OFS);
   end

   dmem_timer u_timer (
      .clk    (clk),
      .reset  (reset),
      .wr_sel (tmr_wr),
      .wdata  (WriteData),
      .count  (tmr_count),
      .cmp    (tmr_cmp),
      .match  (tmr_match)
   );

   assign TimerIrq = tmr_match;
`else
   assign TimerIrq = 1'b0;
`endif

   // RAM decode wins if a large DEPTH ever overlaps the timer window.
   always_comb begin
      ReadData = '0;
      if (aligned) begin
         if (ram_hit) ReadData = mem_q[widx];
`ifdef DMEM_TIMER_EN
         else if (Addr == TIMER_BASE + TMR_COUNT_OFS)  ReadData = tmr_count;
         else if (Addr == TIMER_BASE + TMR_CMP_OFS)    ReadData = tmr_cmp;
         else if (Addr == TIMER_BASE + TMR_STATUS_OFS) ReadData = 32'(tmr_match) << TMR_MATCH_BIT;
`endif
      end
   end

endmodule
